arb21_rr: RTL and testbench

//  Two-source packet arbiter with round-robin fairness. Upstream of the 2:1 select mux.

---
 rtl/arb21_rr_pkg.sv | 17 +
 rtl/arb21_grant.sv | 36 +++
 rtl/arb21_rr.sv | 110 +++++++++++
 tb/tb_arb21_rr.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/arb21_rr_pkg.sv
// Shared types and helpers for the two-source round-robin packet arbiter.
package arb21_rr_pkg;

  localparam int unsigned DataWidth = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StBusy0 = 2'd1,
    StBusy1 = 2'd2
  } state_e;

  // Source to grant when starting a packet; a tie goes to the source named by pri.
  function automatic logic rr_pick_src(input logic req0, input logic req1, input logic pri);
    return req1 & (~req0 | pri);
  endfunction

endpackage

// File: rtl/arb21_grant.sv
// Idle-state pick logic and the round-robin priority register.
module arb21_grant
  import arb21_rr_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  input  logic done,
  input  logic gnt_src,
  output logic pick,
  output logic pick_src
);

  logic pri_q, pri_d;

  // Priority flips away from the source that just finished a packet.
  always_comb begin
    pri_d = pri_q;
    if (done) begin
      pri_d = ~gnt_src;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pri_q <= 1'b0;
    end else begin
      pri_q <= pri_d;
    end
  end

  assign pick     = req0 | req1;
  assign pick_src = rr_pick_src(req0, req1, pri_q);

endmodule

// File: rtl/arb21_rr.sv
// Two-source packet arbiter: locks a grant per packet and forwards beats through
// a one-entry output register.
module arb21_rr
  import arb21_rr_pkg::*;
#(
  parameter int unsigned W = DataWidth
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         d0_valid,
  input  logic [W-1:0] d0_data,
  input  logic         d0_last,
  output logic         d0_ready,
  input  logic         d1_valid,
  input  logic [W-1:0] d1_data,
  input  logic         d1_last,
  output logic         d1_ready,
  output logic         y_valid,
  output logic [W-1:0] y_data,
  output logic         y_last,
  input  logic         y_ready,
  output logic         s
);

  state_e         state_q, state_d;
  logic           y_valid_q, y_valid_d;
  logic [W-1:0]   y_data_q, y_data_d;
  logic           y_last_q, y_last_d;

  logic           gnt_src, busy, out_free;
  logic           src_valid, src_last;
  logic [W-1:0]   src_data;
  logic           xfer, done;
  logic           pick, pick_src;

  always_comb begin
    gnt_src   = (state_q == StBusy1);
    busy      = (state_q == StBusy0) | (state_q == StBusy1);
    src_valid = gnt_src ? d1_valid : d0_valid;
    src_data  = gnt_src ? d1_data  : d0_data;
    src_last  = gnt_src ? d1_last  : d0_last;
    // The output register can take a beat if it is empty or draining this cycle.
    out_free  = ~y_valid_q | y_ready;
    xfer      = busy & src_valid & out_free;
    done      = xfer & src_last;
  end

  arb21_grant u_grant (
    .clk      (clk),
    .rst      (rst),
    .req0     (d0_valid),
    .req1     (d1_valid),
    .done     (done),
    .gnt_src  (gnt_src),
    .pick     (pick),
    .pick_src (pick_src)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (pick) begin
          state_d = pick_src ? StBusy1 : StBusy0;
        end
      end
      StBusy0, StBusy1: begin
        if (done) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    y_valid_d = y_valid_q;
    y_data_d  = y_data_q;
    y_last_d  = y_last_q;
    if (xfer) begin
      y_valid_d = 1'b1;
      y_data_d  = src_data;
      y_last_d  = src_last;
    end else if (y_ready) begin
      y_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      y_valid_q <= 1'b0;
      y_data_q  <= '0;
      y_last_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      y_valid_q <= y_valid_d;
      y_data_q  <= y_data_d;
      y_last_q  <= y_last_d;
    end
  end

  assign d0_ready = (state_q == StBusy0) & out_free;
  assign d1_ready = (state_q == StBusy1) & out_free;
  assign s        = gnt_src;
  assign y_valid  = y_valid_q;
  assign y_data   = y_data_q;
  assign y_last   = y_last_q;

endmodule

// File: tb/tb_arb21_rr.sv
// Directed bench for arb21_rr: per-cycle checks against hand-derived timelines.
module tb_arb21_rr;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       d0_valid = 1'b0, d1_valid = 1'b0;
  logic [7:0] d0_data, d1_data;
  logic       d0_last, d1_last;
  logic       d0_ready, d1_ready;
  logic       y_valid, y_last, y_ready = 1'b1;
  logic [7:0] y_data;
  logic       s;

  // Each source presents base + idx + 1, with last on every len-th beat.
  int         idx0 = 0, idx1 = 0, len0 = 3, len1 = 3;
  logic [7:0] base0 = 8'h00, base1 = 8'h10;
  int         n_checks = 0, n_pass = 0;

  assign d0_data = base0 + 8'(idx0 + 1);
  assign d1_data = base1 + 8'(idx1 + 1);
  assign d0_last = (idx0 % len0) == (len0 - 1);
  assign d1_last = (idx1 % len1) == (len1 - 1);

  always #5 clk = ~clk;

  arb21_rr #(.W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .d0_valid (d0_valid),
    .d0_data  (d0_data),
    .d0_last  (d0_last),
    .d0_ready (d0_ready),
    .d1_valid (d1_valid),
    .d1_data  (d1_data),
    .d1_last  (d1_last),
    .d1_ready (d1_ready),
    .y_valid  (y_valid),
    .y_data   (y_data),
    .y_last   (y_last),
    .y_ready  (y_ready),
    .s        (s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; sources step to their next beat on an accepted handshake.
  task automatic tick();
    logic a0, a1;
    @(negedge clk);
    a0 = d0_valid & d0_ready & ~rst;
    a1 = d1_valid & d1_ready & ~rst;
    @(posedge clk);
    #1;
    if (a0 === 1'b1) idx0++;
    if (a1 === 1'b1) idx1++;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    d0_valid = 1'b0;
    d1_valid = 1'b0;
    y_ready  = 1'b1;
    tick();
    rst  = 1'b0;
    idx0 = 0;
    idx1 = 0;
  endtask

  logic [9:0] e2_v = 10'b1011101110;
  logic [9:0] e2_s = 10'b0001110000;
  logic [9:0] e2_l = 10'b0010001000;
  int         e2_d [10] = '{'h00, 'h01, 'h02, 'h03, 'h00, 'h11, 'h12, 'h13, 'h00, 'h04};

  initial begin
    // Reset with both sources requesting.
    rst = 1'b1; d0_valid = 1'b1; d1_valid = 1'b1; y_ready = 1'b1;
    tick();
    check("t1 rst y_valid", 32'(y_valid), 0);
    check("t1 rst s", 32'(s), 0);
    check("t1 rst d0_ready", 32'(d0_ready), 0);
    check("t1 rst d1_ready", 32'(d1_ready), 0);
    tick();
    rst = 1'b0;
    #1;
    check("t1 post d0_ready", 32'(d0_ready), 0);
    check("t1 post d1_ready", 32'(d1_ready), 0);
    check("t1 post y_valid", 32'(y_valid), 0);

    // Continuous 3-beat packets from both sources: alternation with bubbles.
    for (int c = 1; c <= 10; c++) begin
      tick();
      check($sformatf("t2 y_valid c%0d", c), 32'(y_valid), 32'(e2_v[c-1]));
      check($sformatf("t2 s c%0d", c), 32'(s), 32'(e2_s[c-1]));
      if (e2_v[c-1]) begin
        check($sformatf("t2 y_data c%0d", c), 32'(y_data), 32'(e2_d[c-1]));
        check($sformatf("t2 y_last c%0d", c), 32'(y_last), 32'(e2_l[c-1]));
      end
    end

    // Only d1 requests with pri=0: granted at once, beats on y at N+2 and N+3.
    do_reset();
    base1 = 8'hA0; len1 = 2; d1_valid = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 3) d1_valid = 1'b0;
      #1;
      case (c)
        1: begin
          check("t3 s c1", 32'(s), 1);
          check("t3 d1_ready c1", 32'(d1_ready), 1);
          check("t3 d0_ready c1", 32'(d0_ready), 0);
          check("t3 y_valid c1", 32'(y_valid), 0);
        end
        2: begin
          check("t3 y_valid c2", 32'(y_valid), 1);
          check("t3 y_data c2", 32'(y_data), 'hA1);
          check("t3 y_last c2", 32'(y_last), 0);
        end
        3: begin
          check("t3 y_data c3", 32'(y_data), 'hA2);
          check("t3 y_last c3", 32'(y_last), 1);
          check("t3 s c3", 32'(s), 0);
        end
        default: check("t3 y_valid c4", 32'(y_valid), 0);
      endcase
    end

    // Sink stall for 4 cycles in the middle of a 4-beat d0 packet.
    do_reset();
    base0 = 8'h40; len0 = 4; d0_valid = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c >= 3 && c <= 6) y_ready = 1'b0;
      if (c == 7) y_ready = 1'b1;
      if (c == 9) d0_valid = 1'b0;
      #1;
      if (c >= 3 && c <= 6) begin
        check($sformatf("t4 hold y_valid c%0d", c), 32'(y_valid), 1);
        check($sformatf("t4 hold y_data c%0d", c), 32'(y_data), 'h42);
        check($sformatf("t4 hold d0_ready c%0d", c), 32'(d0_ready), 0);
      end else if (c == 7) begin
        check("t4 rel y_data c7", 32'(y_data), 'h42);
        check("t4 rel d0_ready c7", 32'(d0_ready), 1);
      end else if (c == 8) begin
        check("t4 y_data c8", 32'(y_data), 'h43);
        check("t4 y_last c8", 32'(y_last), 0);
      end else if (c == 9) begin
        check("t4 y_data c9", 32'(y_data), 'h44);
        check("t4 y_last c9", 32'(y_last), 1);
      end else if (c == 10) begin
        check("t4 y_valid c10", 32'(y_valid), 0);
      end
    end

    // d0 gaps mid-packet while d1 waits, then reset in the middle of a d1 packet.
    do_reset();
    base0 = 8'h50; len0 = 3; base1 = 8'h60; len1 = 3;
    d0_valid = 1'b1; d1_valid = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      tick();
      if (c == 2 || c == 3) d0_valid = 1'b0;
      if (c == 4) d0_valid = 1'b1;
      if (c == 8) rst = 1'b1;
      if (c == 9) rst = 1'b0;
      #1;
      case (c)
        2: begin
          check("t5 y_data c2", 32'(y_data), 'h51);
          check("t5 s c2", 32'(s), 0);
          check("t5 d1_ready c2", 32'(d1_ready), 0);
        end
        3: begin
          check("t5 y_valid c3", 32'(y_valid), 0);
          check("t5 s c3", 32'(s), 0);
          check("t5 d1_ready c3", 32'(d1_ready), 0);
        end
        4: begin
          check("t5 d0_ready c4", 32'(d0_ready), 1);
          check("t5 s c4", 32'(s), 0);
          check("t5 d1_ready c4", 32'(d1_ready), 0);
        end
        5: check("t5 y_data c5", 32'(y_data), 'h52);
        6: begin
          check("t5 y_data c6", 32'(y_data), 'h53);
          check("t5 y_last c6", 32'(y_last), 1);
        end
        7: check("t5 s c7", 32'(s), 1);
        8: begin
          check("t6 y_data c8", 32'(y_data), 'h61);
          check("t6 s c8", 32'(s), 1);
        end
        9: begin
          check("t6 y_valid c9", 32'(y_valid), 0);
          check("t6 s c9", 32'(s), 0);
          check("t6 d0_ready c9", 32'(d0_ready), 0);
          check("t6 d1_ready c9", 32'(d1_ready), 0);
        end
        10: begin
          check("t6 s c10", 32'(s), 0);
          check("t6 d0_ready c10", 32'(d0_ready), 1);
          check("t6 d1_ready c10", 32'(d1_ready), 0);
        end
        11: check("t6 y_data c11", 32'(y_data), 'h54);
        default: ;
      endcase
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
